pipeline_trace_buffer: RTL and testbench
========================================

# pipeline_trace_buffer

Parametrised on-chip trace capture for the MIPS pipeline. Samples up to CHANNELS probe words per pipeline cycle, such as instruction, ALU result, write-back data and forwarding selects, into a circular buffer. Freezes the buffer a programmable number of samples after a trigger, then serves the captured window oldest-first to the debug unit. It generalises the bench-only signal monitoring into synthesizable hardware: parametrised width, depth and channel count, plus trigger modes and pre/post-trigger windowing.

## Interface
- DATA_WIDTH, 32, width of one probe channel
- CHANNELS, 4, probe channels captured per sample (1..8)
- DEPTH, 16, samples stored; power of two, ≥4
- POST_TRIGGER, DEPTH/2, samples taken after the trigger sample (0..DEPTH-1)
- ClockIn  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- In_Sample  in  1  probe word valid this cycle (pipeline not stalled)
- In_Probe  in  CHANNELS*DATA_WIDTH  probe words; channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]
- In_Arm  in  1  one-cycle pulse; starts a capture from IDLE or DONE
- In_TrigMode  in  2  0 immediate, 1 channel0 == In_TrigValue, 2 In_ExtTrig high, 3 channel0 != In_TrigValue
- In_TrigValue  in  DATA_WIDTH  compare value
- In_ExtTrig  in  1  external trigger, e.g. hazard-unit stall
- In_RdReq  in  1  read request, honoured only in DONE
- In_RdIndex  in  log2(DEPTH)  sample index, 0 = oldest
- In_RdChan  in  log2(CHANNELS) (min 1)  channel select
- Out_RdValid  out  1  read data valid
- Out_RdData  out  DATA_WIDTH  read data
- Out_State  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- Out_Count  out  log2(DEPTH)+1  valid samples held
- Out_TrigIndex  out  log2(DEPTH)  read index of the trigger sample

## Operation
- IDLE: no writes. In_Arm clears the write pointer and Out_Count, then moves to ARMED.
- ARMED: each In_Sample writes In_Probe at wr_ptr, then wr_ptr++ mod DEPTH and Out_Count saturates at DEPTH.
- The trigger is evaluated only on cycles with In_Sample. When it hits, the triggering sample is stored and its slot is latched as trig_ptr.
  - If POST_TRIGGER==0, go to DONE.
  - Otherwise load post_cnt=POST_TRIGGER and go to POST.
- POST: each In_Sample stores and decrements post_cnt. The sample that brings post_cnt to 0 is stored, then the block goes to DONE.
- DONE: the buffer is frozen and In_Sample is ignored. Oldest slot = (wr_ptr - Out_Count) mod DEPTH.
  - Read address = oldest + In_RdIndex mod DEPTH.
  - Out_TrigIndex = (trig_ptr - oldest) mod DEPTH.
- In_Arm in ARMED or POST is ignored. In_Arm in DONE restarts the capture, as from IDLE.
- In_RdReq outside DONE gives Out_RdValid=0 and leaves Out_RdData unchanged.
- In_RdIndex ≥ Out_Count in DONE gives Out_RdValid=1 and Out_RdData=0.
- Buffer overwrite: the pre-trigger history keeps only the newest DEPTH-1-POST_TRIGGER samples once the post-trigger samples complete. The ring simply wraps.

## Timing
- Reset asserted → Out_State=IDLE, Out_Count=0, Out_TrigIndex=0, Out_RdValid=0, Out_RdData=0, pointers=0. Storage contents are don't-care.
- Arm-to-ARMED: 1 cycle. A sample in the same cycle as In_Arm is not captured.
- Mode 0 triggers on the first In_Sample after arming.
- Trigger sample to DONE: POST_TRIGGER+1 sampled cycles, counting the trigger sample. Out_State=DONE is visible the cycle after the last write.
- Read latency: 1 cycle. Out_RdValid is a one-cycle pulse per request, and back-to-back requests are allowed every cycle.
- In_Arm and In_RdReq in the same DONE cycle: the read completes with pre-arm data, then the state changes to ARMED.
- Reset asserted mid-capture aborts immediately to IDLE.

## Structure
- A shared package `trace_pkg` holds:
  - state encodings TRC_IDLE/ARMED/POST/DONE
  - trigger-mode constants TRG_IMM/EQ/EXT/NEQ
  - a clog2-with-minimum-1 function
- One sub-module, `trace_ram`: single write port, one registered read port, DEPTH × (CHANNELS*DATA_WIDTH). Channel mux after the read.
- The FSM, pointers and trigger compare live in the top.

## Test plan
- Reset mid-POST (DEPTH=16, POST_TRIGGER=8) → next cycle Out_State=0, Out_Count=0, Out_RdValid=0.
- Mode 0, arm, feed 20 samples with channel0=n (n=1..20) → DONE after 9 samples.
  - Out_Count=9, Out_TrigIndex=0.
  - Reads of index 0..8, channel 0 return 1..9.
- Mode 1, TrigValue=30, feed channel0=n for n=1..50 → DONE after n=38; Out_Count=16, Out_TrigIndex=7, index 0 reads 23, index 15 reads 38.
- Mode 2 with In_Sample gated low on alternate cycles and ExtTrig pulsed on a gated-off cycle → no trigger. ExtTrig on a sampled cycle → triggers.
- Read in DONE with CHANNELS=4 and channel k = 100*k+n → channel 3 of the trigger index returns 300+trigger n.
- Out-of-range index → Out_RdValid=1, data=0.
- Re-arm from DONE concurrent with a read → the read returns old data, then Out_State=1 and Out_Count=0. A read while ARMED → Out_RdValid=0.

Source files
------------

// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared types and helpers for the pipeline trace capture block.
package trace_pkg;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_e;

  typedef enum logic [1:0] {
    TRG_IMM = 2'd0,
    TRG_EQ  = 2'd1,
    TRG_EXT = 2'd2,
    TRG_NEQ = 2'd3
  } trg_mode_e;

  // Index width that never collapses to zero bits for single-entry selects.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_ram.sv
// Trace sample storage: one write port, one enabled registered read port.
module trace_ram
  import trace_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // The read register holds its value between requests so the top can
  // keep presenting the last read word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Trace capture for the MIPS pipeline: ring buffer, trigger, post-trigger window, oldest-first readout.
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned POST_TRIGGER = DEPTH / 2
) (
  input  logic                               ClockIn,
  input  logic                               Reset,
  input  logic                               In_Sample,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     In_Probe,
  input  logic                               In_Arm,
  input  logic [1:0]                         In_TrigMode,
  input  logic [DATA_WIDTH-1:0]              In_TrigValue,
  input  logic                               In_ExtTrig,
  input  logic                               In_RdReq,
  input  logic [$clog2(DEPTH)-1:0]           In_RdIndex,
  input  logic [clog2_min1(CHANNELS)-1:0]    In_RdChan,
  output logic                               Out_RdValid,
  output logic [DATA_WIDTH-1:0]              Out_RdData,
  output logic [1:0]                         Out_State,
  output logic [$clog2(DEPTH):0]             Out_Count,
  output logic [$clog2(DEPTH)-1:0]           Out_TrigIndex
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = clog2_min1(CHANNELS);
  localparam int unsigned PW = CHANNELS * DATA_WIDTH;
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIGGER);

  trc_state_e     state_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW:0]    count_q;
  logic [AW-1:0]  trig_ptr_q;
  logic [AW-1:0]  post_cnt_q;
  logic           rd_valid_q;
  logic           rd_inrange_q;
  logic [CW-1:0]  rd_chan_q;

  logic           capture;
  logic           trig_hit;
  logic           rd_en;
  logic           rd_inrange_d;
  logic [AW-1:0]  wr_ptr_d;
  logic [AW:0]    count_d;
  logic [AW-1:0]  oldest;
  logic [AW-1:0]  rd_addr;
  logic [PW-1:0]  rd_row;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    capture  = In_Sample && (state_q == TRC_ARMED || state_q == TRC_POST);
    wr_ptr_d = wr_ptr_q + AW'(1);
    count_d  = (count_q == FULL) ? count_q : count_q + (AW+1)'(1);
    // A full ring gives count low bits of zero, so oldest is the write slot.
    oldest       = wr_ptr_q - count_q[AW-1:0];
    rd_addr      = oldest + In_RdIndex;
    rd_en        = In_RdReq && (state_q == TRC_DONE);
    rd_inrange_d = ({1'b0, In_RdIndex} < count_q);
  end

  always_comb begin
    trig_hit = 1'b0;
    case (trg_mode_e'(In_TrigMode))
      TRG_IMM: trig_hit = 1'b1;
      TRG_EQ:  trig_hit = (In_Probe[DATA_WIDTH-1:0] == In_TrigValue);
      TRG_EXT: trig_hit = In_ExtTrig;
      TRG_NEQ: trig_hit = (In_Probe[DATA_WIDTH-1:0] != In_TrigValue);
      default: trig_hit = 1'b0;
    endcase
  end

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q      <= TRC_IDLE;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      trig_ptr_q   <= '0;
      post_cnt_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_inrange_q <= 1'b0;
      rd_chan_q    <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_inrange_q <= rd_inrange_d;
        rd_chan_q    <= In_RdChan;
      end
      if (capture) begin
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
      end
      case (state_q)
        TRC_IDLE, TRC_DONE: begin
          if (In_Arm) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= TRC_ARMED;
          end
        end
        TRC_ARMED: begin
          if (In_Sample && trig_hit) begin
            trig_ptr_q <= wr_ptr_q;
            if (POST_TRIGGER == 0) begin
              state_q <= TRC_DONE;
            end else begin
              post_cnt_q <= POST_LOAD;
              state_q    <= TRC_POST;
            end
          end
        end
        TRC_POST: begin
          if (In_Sample) begin
            post_cnt_q <= post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) state_q <= TRC_DONE;
          end
        end
        default: state_q <= TRC_IDLE;
      endcase
    end
  end

  trace_ram #(
    .WIDTH (PW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (ClockIn),
    .we_i    (capture),
    .waddr_i (wr_ptr_q),
    .wdata_i (In_Probe),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_row)
  );

  // Channel select and range flag were captured with the request, so the
  // output stays stable until the next honoured read.
  always_comb begin
    rd_data = '0;
    if (rd_inrange_q) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (rd_chan_q == CW'(k)) rd_data = rd_row[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign Out_RdValid   = rd_valid_q;
  assign Out_RdData    = rd_data;
  assign Out_State     = state_q;
  assign Out_Count     = count_q;
  assign Out_TrigIndex = trig_ptr_q - oldest;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Scoreboard bench for pipeline_trace_buffer: directed captures in all trigger modes plus readout.
module tb_pipeline_trace_buffer;

  localparam int DW = 32;
  localparam int CH = 4;
  localparam int DP = 16;
  localparam int PT = 8;

  logic           ClockIn = 1'b0;
  logic           Reset = 1'b1;
  logic           In_Sample = 1'b0;
  logic [CH*DW-1:0] In_Probe = '0;
  logic           In_Arm = 1'b0;
  logic [1:0]     In_TrigMode = 2'd0;
  logic [DW-1:0]  In_TrigValue = '0;
  logic           In_ExtTrig = 1'b0;
  logic           In_RdReq = 1'b0;
  logic [3:0]     In_RdIndex = '0;
  logic [1:0]     In_RdChan = '0;
  logic           Out_RdValid;
  logic [DW-1:0]  Out_RdData;
  logic [1:0]     Out_State;
  logic [4:0]     Out_Count;
  logic [3:0]     Out_TrigIndex;

  pipeline_trace_buffer #(
    .DATA_WIDTH   (DW),
    .CHANNELS     (CH),
    .DEPTH        (DP),
    .POST_TRIGGER (PT)
  ) dut (
    .ClockIn       (ClockIn),
    .Reset         (Reset),
    .In_Sample     (In_Sample),
    .In_Probe      (In_Probe),
    .In_Arm        (In_Arm),
    .In_TrigMode   (In_TrigMode),
    .In_TrigValue  (In_TrigValue),
    .In_ExtTrig    (In_ExtTrig),
    .In_RdReq      (In_RdReq),
    .In_RdIndex    (In_RdIndex),
    .In_RdChan     (In_RdChan),
    .Out_RdValid   (Out_RdValid),
    .Out_RdData    (Out_RdData),
    .Out_State     (Out_State),
    .Out_Count     (Out_Count),
    .Out_TrigIndex (Out_TrigIndex)
  );

  always #5 ClockIn = ~ClockIn;

  typedef struct {
    int          due;
    bit          valid;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] exp_last = '0;

  always @(posedge ClockIn) cyc++;

  // Read monitor: compares the DUT's read response against the queued expectation.
  always @(posedge ClockIn) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (Out_RdValid !== e.valid || Out_RdData !== e.data) begin
        errors++;
        $display("FAIL read@%0d: got valid=%0b data=%0d, expected valid=%0b data=%0d",
                 cyc, Out_RdValid, Out_RdData, e.valid, e.data);
      end
    end else if (Out_RdValid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_valid@%0d: got valid=1 data=%0d, expected no response", cyc, Out_RdData);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [CH*DW-1:0] probe(input int n);
    return {32'(300 + n), 32'(200 + n), 32'(100 + n), 32'(n)};
  endfunction

  task automatic tick;
    @(posedge ClockIn);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_rd(input int idx, input int chan, input bit v, input logic [31:0] d);
    exp_t e;
    In_RdReq   = 1'b1;
    In_RdIndex = 4'(idx);
    In_RdChan  = 2'(chan);
    e.due   = cyc + 1;
    e.valid = v;
    e.data  = v ? d : exp_last;
    if (v) exp_last = d;
    exp_q.push_back(e);
  endtask

  task automatic rd(input int idx, input int chan, input bit v, input logic [31:0] d);
    push_rd(idx, chan, v, d);
    tick();
    In_RdReq = 1'b0;
  endtask

  task automatic arm;
    In_Arm = 1'b1;
    tick();
    In_Arm = 1'b0;
  endtask

  task automatic feed(input int nmax, output int done_n);
    done_n = 0;
    for (int n = 1; n <= nmax; n++) begin
      In_Sample = 1'b1;
      In_Probe  = probe(n);
      tick();
      if (done_n == 0 && Out_State == 2'd3) done_n = n;
    end
    In_Sample = 1'b0;
  endtask

  initial begin
    int done_n;
    #1 Reset = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(Out_State), 0);
    chk("rst_count", 32'(Out_Count), 0);
    chk("rst_trigidx", 32'(Out_TrigIndex), 0);
    chk("rst_rdvalid", 32'(Out_RdValid), 0);
    chk("rst_rddata", Out_RdData, 0);
    Reset = 1'b1;
    tick();

    // Mode 0: immediate trigger; sample on the arm cycle must not be stored.
    In_TrigMode = 2'd0;
    In_Sample   = 1'b1;
    In_Probe    = probe(99);
    arm();
    In_Sample   = 1'b0;
    chk("m0_armed", 32'(Out_State), 1);
    chk("m0_arm_count", 32'(Out_Count), 0);
    feed(20, done_n);
    chk("m0_done_n", done_n, 9);
    chk("m0_state", 32'(Out_State), 3);
    chk("m0_count", 32'(Out_Count), 9);
    chk("m0_trigidx", 32'(Out_TrigIndex), 0);
    for (int i = 0; i < 9; i++) rd(i, 0, 1'b1, 32'(i + 1));
    rd(8, 3, 1'b1, 309);
    rd(4, 1, 1'b1, 105);
    rd(9, 0, 1'b1, 0);
    rd(15, 2, 1'b1, 0);

    // Re-arm concurrent with a read, then a read while ARMED.
    In_TrigMode  = 2'd1;
    In_TrigValue = 32'd30;
    In_Arm = 1'b1;
    push_rd(2, 0, 1'b1, 3);
    tick();
    In_Arm   = 1'b0;
    In_RdReq = 1'b0;
    chk("rearm_state", 32'(Out_State), 1);
    chk("rearm_count", 32'(Out_Count), 0);
    rd(0, 0, 1'b0, 0);

    // Mode 1: channel0 == 30, ring wraps.
    feed(50, done_n);
    chk("m1_done_n", done_n, 38);
    chk("m1_count", 32'(Out_Count), 16);
    chk("m1_trigidx", 32'(Out_TrigIndex), 7);
    rd(0, 0, 1'b1, 23);
    rd(15, 0, 1'b1, 38);
    rd(7, 3, 1'b1, 330);

    // Mode 2: external trigger only counts on sampled cycles.
    In_TrigMode = 2'd2;
    arm();
    done_n = 0;
    for (int t = 0; t < 40; t++) begin
      In_Sample  = (t % 2 == 0);
      In_Probe   = probe(t / 2 + 1);
      In_ExtTrig = (t == 5 || t == 10);
      tick();
      if (t == 9) chk("m2_no_gated_trig", 32'(Out_State), 1);
      if (done_n == 0 && Out_State == 2'd3) done_n = t / 2 + 1;
    end
    In_Sample  = 1'b0;
    In_ExtTrig = 1'b0;
    chk("m2_done_n", done_n, 14);
    chk("m2_count", 32'(Out_Count), 14);
    chk("m2_trigidx", 32'(Out_TrigIndex), 5);
    rd(5, 3, 1'b1, 306);
    rd(0, 0, 1'b1, 1);
    rd(13, 0, 1'b1, 14);

    // Mode 3: channel0 != 1 fires on the second sample.
    In_TrigMode  = 2'd3;
    In_TrigValue = 32'd1;
    arm();
    feed(30, done_n);
    chk("m3_done_n", done_n, 10);
    chk("m3_count", 32'(Out_Count), 10);
    chk("m3_trigidx", 32'(Out_TrigIndex), 1);
    rd(1, 2, 1'b1, 202);

    // Asynchronous reset while in POST.
    In_TrigMode = 2'd0;
    arm();
    feed(3, done_n);
    chk("post_state", 32'(Out_State), 2);
    Reset = 1'b0;
    #1;
    chk("rstpost_state", 32'(Out_State), 0);
    chk("rstpost_count", 32'(Out_Count), 0);
    chk("rstpost_rdvalid", 32'(Out_RdValid), 0);
    chk("rstpost_rddata", Out_RdData, 0);
    exp_last = '0;
    tick();
    Reset = 1'b1;
    tick();
    arm();
    chk("post_rst_arm", 32'(Out_State), 1);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
